// File: rtl/cb_synthesis_if.sv
// Bus between the codebook generator, the node memory and the header writer.
interface cb_synthesis_if;
    logic [6:0]   max_index;
    logic [70:0]  h_element;
    logic         write_finish;
    logic [6:0]   curr_index;
    logic [127:0] curr_path;
    logic [6:0]   track_length;
    logic [6:0]   pos;
    logic [127:0] char_path;
    logic [7:0]   char_index;
    logic         char_found;
    logic [8:0]   least1;
    logic [8:0]   least2;
    logic [2:0]   curr_state;
    logic [3:0]   finished;
    logic         wait_cycle;

    modport master (
        input  max_index, h_element, write_finish,
        output curr_index, curr_path, track_length, pos, char_path, char_index,
               char_found, least1, least2, curr_state, finished, wait_cycle
    );

    modport slave (
        output max_index, h_element, write_finish,
        input  curr_index, curr_path, track_length, pos, char_path, char_index,
               char_found, least1, least2, curr_state, finished, wait_cycle
    );
endinterface

// File: rtl/cb_synthesis.sv
// Huffman codebook generator: depth-first walk of the node memory, emitting every leaf's
// character, code path and code length, stalling on each until the header writer acks.
module cb_synthesis (
    input logic            clk,
    input logic            rst,
    cb_synthesis_if.master bus
);

    typedef enum logic [2:0] {
        StLeft      = 3'd0,
        StRight     = 3'd1,
        StTrack     = 3'd2,
        StBacktrack = 3'd3,
        StFinish    = 3'd4,
        StInit      = 3'd5,
        StSend      = 3'd6
    } state_e;

    state_e       state_q, state_d, next_q, next_d;
    logic [6:0]   curr_index_q, curr_index_d;
    logic [127:0] curr_path_q, curr_path_d;
    logic [6:0]   track_length_q, track_length_d;
    logic [6:0]   pos_q, pos_d;
    logic [127:0] char_path_q, char_path_d;
    logic [7:0]   char_index_q, char_index_d;
    logic         char_found_q, char_found_d;
    logic [8:0]   least1_q, least1_d, least2_q, least2_d;
    logic [3:0]   finished_q, finished_d;
    logic         wait_q, wait_d;

    logic [8:0]   left_child, right_child;
    logic [7:0]   code_len;
    logic [127:0] code_mask;

    assign left_child  = bus.h_element[63:55];
    assign right_child = bus.h_element[54:46];
    // Stale bits above the current depth are masked out of the emitted code.
    assign code_len    = {1'b0, track_length_q} + 8'd1;
    assign code_mask   = ~({128{1'b1}} << code_len);

    // Next-state logic for the walk; every state action is skipped during a wait cycle.
    always_comb begin
        state_d        = state_q;
        next_d         = next_q;
        curr_index_d   = curr_index_q;
        curr_path_d    = curr_path_q;
        track_length_d = track_length_q;
        pos_d          = pos_q;
        char_path_d    = char_path_q;
        char_index_d   = char_index_q;
        char_found_d   = char_found_q;
        least1_d       = least1_q;
        least2_d       = least2_q;
        finished_d     = finished_q;
        wait_d         = 1'b0;
        if (!wait_q) begin
            least1_d = left_child;
            least2_d = right_child;
            unique case (state_q)
                StInit: begin
                    curr_index_d   = bus.max_index;
                    curr_path_d    = '0;
                    track_length_d = '0;
                    state_d        = StLeft;
                end
                StLeft: begin
                    curr_path_d[track_length_q] = 1'b0;
                    if (left_child[8]) begin
                        curr_index_d   = left_child[6:0];
                        track_length_d = track_length_q + 7'd1;
                    end else begin
                        // Depth shows the code length while in SEND; restored on ack.
                        char_path_d    = curr_path_d & code_mask;
                        char_index_d   = left_child[7:0];
                        track_length_d = track_length_q + 7'd1;
                        char_found_d   = 1'b1;
                        next_d         = StRight;
                        state_d        = StSend;
                    end
                end
                StRight: begin
                    curr_path_d[track_length_q] = 1'b1;
                    if (right_child[8]) begin
                        curr_index_d   = right_child[6:0];
                        track_length_d = track_length_q + 7'd1;
                        state_d        = StLeft;
                    end else begin
                        char_path_d    = curr_path_d & code_mask;
                        char_index_d   = right_child[7:0];
                        track_length_d = track_length_q + 7'd1;
                        char_found_d   = 1'b1;
                        next_d         = StBacktrack;
                        state_d        = StSend;
                    end
                end
                StSend: begin
                    if (bus.write_finish) begin
                        char_found_d   = 1'b0;
                        track_length_d = track_length_q - 7'd1;
                        state_d        = next_q;
                    end
                end
                StBacktrack: begin
                    if (track_length_q == 7'd0) begin
                        state_d = StFinish;
                    end else if (curr_path_q[track_length_q - 7'd1]) begin
                        curr_path_d[track_length_q - 7'd1] = 1'b0;
                        track_length_d = track_length_q - 7'd1;
                    end else begin
                        // That ancestor still owes its right subtree: retrace from the root.
                        track_length_d = track_length_q - 7'd1;
                        pos_d          = '0;
                        curr_index_d   = bus.max_index;
                        state_d        = StTrack;
                    end
                end
                StTrack: begin
                    if (pos_q == track_length_q) begin
                        state_d = StRight;
                    end else begin
                        curr_index_d = curr_path_q[pos_q] ? right_child[6:0] : left_child[6:0];
                        pos_d        = pos_q + 7'd1;
                    end
                end
                StFinish: begin
                    finished_d   = 4'd1;
                    char_found_d = 1'b0;
                end
                default: state_d = StInit;
            endcase
            // Node word lags the address by a cycle, so hold for one after any move.
            wait_d = (curr_index_d != curr_index_q);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StInit;
            next_q         <= StLeft;
            curr_index_q   <= '0;
            curr_path_q    <= '0;
            track_length_q <= '0;
            pos_q          <= '0;
            char_path_q    <= '0;
            char_index_q   <= '0;
            char_found_q   <= 1'b0;
            least1_q       <= '0;
            least2_q       <= '0;
            finished_q     <= '0;
            wait_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            next_q         <= next_d;
            curr_index_q   <= curr_index_d;
            curr_path_q    <= curr_path_d;
            track_length_q <= track_length_d;
            pos_q          <= pos_d;
            char_path_q    <= char_path_d;
            char_index_q   <= char_index_d;
            char_found_q   <= char_found_d;
            least1_q       <= least1_d;
            least2_q       <= least2_d;
            finished_q     <= finished_d;
            wait_q         <= wait_d;
        end
    end

    assign bus.curr_index   = curr_index_q;
    assign bus.curr_path    = curr_path_q;
    assign bus.track_length = track_length_q;
    assign bus.pos          = pos_q;
    assign bus.char_path    = char_path_q;
    assign bus.char_index   = char_index_q;
    assign bus.char_found   = char_found_q;
    assign bus.least1       = least1_q;
    assign bus.least2       = least2_q;
    assign bus.curr_state   = state_q;
    assign bus.finished     = finished_q;
    assign bus.wait_cycle   = wait_q;

endmodule

// File: tb/tb_cb_synthesis.sv
// Bench for cb_synthesis: node memory model plus a scoreboard of expected codes.
module tb_cb_synthesis;

    logic clk;
    logic rst;
    cb_synthesis_if bus ();

    cb_synthesis dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [70:0] mem [0:127];

    // Node memory: one cycle of read latency.
    always @(posedge clk) bus.h_element <= mem[bus.curr_index];

    typedef struct {
        logic [7:0]   ch;
        logic [127:0] path;
        logic [6:0]   len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] node(input logic [8:0] l, input logic [8:0] r);
        return {7'd0, l, r, 46'd0};
    endfunction

    function automatic logic [8:0] nd(input int idx);
        return {1'b1, 8'(idx)};
    endfunction

    function automatic logic [8:0] lf(input byte c);
        return {1'b0, c};
    endfunction

    // Expected entry from a character and its code written bit0-first.
    task automatic push_exp(input byte c, input string s);
        exp_t e;
        e.ch   = c;
        e.path = '0;
        for (int i = 0; i < s.len(); i++) if (s[i] == "1") e.path[i] = 1'b1;
        e.len  = 7'(s.len());
        exp_q.push_back(e);
    endtask

    task automatic push_tree1();
        exp_q.delete();
        push_exp("C", "0000"); push_exp("B", "0001"); push_exp("A", "001");
        push_exp("F", "010");  push_exp("D", "0110"); push_exp("E", "0111");
        push_exp("J", "10");   push_exp("G", "110");  push_exp("H", "1110");
        push_exp("I", "1111");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state();
        check_eq("rst_state", 128'(bus.curr_state), 128'd5);
        check_eq("rst_index", 128'(bus.curr_index), 128'd0);
        check_eq("rst_path", bus.curr_path, 128'd0);
        check_eq("rst_len", 128'(bus.track_length), 128'd0);
        check_eq("rst_pos", 128'(bus.pos), 128'd0);
        check_eq("rst_cpath", bus.char_path, 128'd0);
        check_eq("rst_cidx", 128'(bus.char_index), 128'd0);
        check_eq("rst_found", 128'(bus.char_found), 128'd0);
        check_eq("rst_least", 128'({bus.least1, bus.least2}), 128'd0);
        check_eq("rst_fin", 128'(bus.finished), 128'd0);
        check_eq("rst_wait", 128'(bus.wait_cycle), 128'd0);
    endtask

    // Wait for the next char, score it, optionally stall, then ack it.
    task automatic ack_one(input int hold);
        exp_t e;
        int   n = 0;
        while (bus.char_found !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (bus.char_found !== 1'b1) begin
            check_eq("char_timeout", 128'(bus.char_found), 128'd1);
        end else if (exp_q.size() == 0) begin
            check_eq("sb_extra_char", 128'(bus.char_index), 128'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("char_index", 128'(bus.char_index), 128'(e.ch));
            check_eq("char_path", bus.char_path, e.path);
            check_eq("char_len", 128'(bus.track_length), 128'(e.len));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("hold_found", 128'(bus.char_found), 128'd1);
                check_eq("hold_index", 128'(bus.char_index), 128'(e.ch));
                check_eq("hold_path", bus.char_path, e.path);
                check_eq("hold_state", 128'(bus.curr_state), 128'd6);
            end
        end
        bus.write_finish = 1'b1;
        @(negedge clk);
        bus.write_finish = 1'b0;
        check_eq("ack_clear", 128'(bus.char_found), 128'd0);
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        int n = 0;
        while (bus.curr_state !== st && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 128'(bus.curr_state), 128'(st));
    endtask

    task automatic check_finish();
        wait_state(3'd4, "finish_state");
        @(negedge clk);
        check_eq("finished", 128'(bus.finished), 128'd1);
        repeat (10) @(negedge clk);
        check_eq("finish_hold", 128'(bus.curr_state), 128'd4);
        check_eq("finished_hold", 128'(bus.finished), 128'd1);
        check_eq("finish_nochar", 128'(bus.char_found), 128'd0);
        check_eq("sb_drained", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic load_tree1();
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[0] = node(lf("C"), lf("B"));
        mem[1] = node(lf("D"), lf("E"));
        mem[2] = node(lf("H"), lf("I"));
        mem[3] = node(nd(0), lf("A"));
        mem[4] = node(lf("F"), nd(1));
        mem[5] = node(lf("G"), nd(2));
        mem[6] = node(nd(3), nd(4));
        mem[7] = node(lf("J"), nd(5));
        mem[8] = node(nd(6), nd(7));
    endtask

    initial begin
        rst              = 1'b1;
        bus.max_index    = 7'd8;
        bus.write_finish = 1'b0;
        bus.h_element    = '0;
        load_tree1();
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        // Full walk; the first char is held unacknowledged for 20 cycles.
        push_tree1();
        for (int i = 0; i < 10; i++) ack_one(i == 0 ? 20 : 0);
        check_finish();

        // Abort during TRACK, then rerun from scratch.
        do_reset();
        push_tree1();
        for (int i = 0; i < 3; i++) ack_one(0);
        wait_state(3'd2, "reach_track");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        push_tree1();
        for (int i = 0; i < 10; i++) ack_one(0);
        check_finish();

        // Root with two leaves.
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[0] = node(lf("X"), lf("Y"));
        bus.max_index = 7'd0;
        do_reset();
        exp_q.delete();
        push_exp("X", "0");
        push_exp("Y", "1");
        for (int i = 0; i < 2; i++) ack_one(0);
        check_finish();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
